// File: rtl/audio_stream_pkg.sv
// Shared types, widths and defaults for the sample streamer.
// Pace-counter width and underrun saturation helpers live here so every block agrees.
package audio_stream_pkg;

    localparam int SAMPLE_W              = 16;
    localparam int CLK_DIV_DEFAULT       = 2268;
    localparam int INTERVAL_LEN_DEFAULT  = 44100;
    localparam int NUM_INTERVALS_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A divide-by-one pacer still needs a one-bit counter to stay legal.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/sample_streamer_if.sv
// Host write port and emitted sample stream of the sample streamer.
interface sample_streamer_if;
    import audio_stream_pkg::*;

    logic signed [SAMPLE_W-1:0] wr_data;
    logic                       wr_valid;
    logic                       wr_ready;
    logic signed [SAMPLE_W-1:0] audio_sample;
    logic                       sample_valid;
    logic                       interval_last;

    modport master (
        output wr_data, wr_valid,
        input  wr_ready, audio_sample, sample_valid, interval_last
    );

    modport slave (
        input  wr_data, wr_valid,
        output wr_ready, audio_sample, sample_valid, interval_last
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with the head word always visible; pop advances the head.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (wptr_r == rptr_r);
    assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = mem_r[rptr_r[AW-1:0]];

    // Read/write pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + (AW+1)'(1);
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/sample_streamer.sv
// Paces queued host samples out at a fixed rate, zero-filling on underrun,
// and tracks interval/run boundaries for a fixed-length playback run.
module sample_streamer
    import audio_stream_pkg::*;
#(
    parameter int CLK_DIV       = CLK_DIV_DEFAULT,
    parameter int INTERVAL_LEN  = INTERVAL_LEN_DEFAULT,
    parameter int NUM_INTERVALS = NUM_INTERVALS_DEFAULT,
    parameter int DEPTH         = 64
) (
    input  logic                clk,
    input  logic                rst,
    sample_streamer_if.slave    bus,
    input  logic                start,
    input  logic                stop,
    output logic                busy,
    output logic                done,
    output logic [15:0]         underrun_count
);

    localparam int                PACE_W      = cnt_width(CLK_DIV);
    localparam logic [PACE_W-1:0] PACE_MAX    = PACE_W'(CLK_DIV - 1);
    localparam logic [31:0]       LAST_SAMPLE = 32'(INTERVAL_LEN - 1);
    localparam logic [31:0]       LAST_IVAL   = 32'(NUM_INTERVALS - 1);

    state_t                      state_r;
    state_t                      state_next_s;
    logic                        armed_r;
    logic [PACE_W-1:0]           pace_r;
    logic [31:0]                 sample_cnt_r;
    logic [31:0]                 interval_cnt_r;
    logic [15:0]                 underrun_r;
    logic signed [SAMPLE_W-1:0]  audio_r;
    logic                        valid_r;
    logic                        last_r;
    logic signed [SAMPLE_W-1:0]  head_s;
    logic                        full_s;
    logic                        empty_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        tick_s;
    logic                        finish_s;
    logic                        enter_run_s;

    // Run ends once the final interval's last sample has been presented.
    assign finish_s    = (state_r == ST_RUN) && valid_r && last_r && (interval_cnt_r == LAST_IVAL);
    assign tick_s      = (state_r == ST_RUN) && (pace_r == PACE_MAX) && !stop && !finish_s;
    assign pop_s       = tick_s && !empty_s;
    assign push_s      = bus.wr_valid && !full_s;
    assign enter_run_s = (state_r != ST_RUN) && (state_next_s == ST_RUN);

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (bus.wr_data),
        .head    (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // State register; DONE only re-arms after start has been seen low there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            armed_r <= (state_r == ST_DONE) && (armed_r || !start);
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next_s = ST_IDLE;
                end else if (finish_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start && armed_r) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Pace, sample, interval and underrun counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pace_r         <= '0;
            sample_cnt_r   <= 32'd0;
            interval_cnt_r <= 32'd0;
            underrun_r     <= 16'd0;
        end else if (enter_run_s) begin
            pace_r         <= '0;
            sample_cnt_r   <= 32'd0;
            interval_cnt_r <= 32'd0;
            underrun_r     <= 16'd0;
        end else if (state_r == ST_RUN) begin
            pace_r <= (pace_r == PACE_MAX) ? '0 : pace_r + PACE_W'(1);
            if (tick_s) begin
                sample_cnt_r <= (sample_cnt_r == LAST_SAMPLE) ? 32'd0 : sample_cnt_r + 32'd1;
                if (empty_s) begin
                    underrun_r <= sat_inc16(underrun_r);
                end
            end
            if (valid_r && last_r) begin
                interval_cnt_r <= interval_cnt_r + 32'd1;
            end
        end else begin
            pace_r <= '0;
        end
    end

    // Output sample register; the sample holds between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            audio_r <= {SAMPLE_W{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            valid_r <= tick_s;
            last_r  <= tick_s && (sample_cnt_r == LAST_SAMPLE);
            if (tick_s) begin
                audio_r <= empty_s ? {SAMPLE_W{1'b0}} : head_s;
            end
        end
    end

    assign bus.audio_sample  = audio_r;
    assign bus.sample_valid  = valid_r;
    assign bus.interval_last = last_r;
    assign bus.wr_ready      = !full_s;
    assign busy              = (state_r == ST_RUN);
    assign done              = (state_r == ST_DONE);
    assign underrun_count    = underrun_r;

endmodule

// File: tb/tb_sample_streamer.sv
// Directed/randomized bench for sample_streamer against a queue-based playback model.
module tb_sample_streamer;

    localparam int CD = 4;
    localparam int IL = 8;
    localparam int NI = 2;
    localparam int DP = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic [15:0] underrun_count;
    logic        sstart;
    logic        sstop;
    logic        s_busy;
    logic        s_done;
    logic [15:0] s_under;

    sample_streamer_if bus ();
    sample_streamer_if sbus ();

    sample_streamer #(.CLK_DIV(CD), .INTERVAL_LEN(IL), .NUM_INTERVALS(NI), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .bus(bus), .start(start), .stop(stop),
        .busy(busy), .done(done), .underrun_count(underrun_count)
    );

    sample_streamer #(.CLK_DIV(1), .INTERVAL_LEN(8), .NUM_INTERVALS(10000), .DEPTH(DP)) sat_dut (
        .clk(clk), .rst(rst), .bus(sbus), .start(sstart), .stop(sstop),
        .busy(s_busy), .done(s_done), .underrun_count(s_under)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Playback model: a queue for the FIFO, an age counter since entering RUN
    logic signed [15:0] q [$];
    bit                 m_run, m_done, m_armed, m_finish;
    int                 m_age, m_strobes, m_under;
    logic signed [15:0] m_sample;
    bit                 m_valid, m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_run = 0; m_done = 0; m_armed = 0; m_finish = 0;
        m_age = 0; m_strobes = 0; m_under = 0; m_sample = 16'sd0;
    endtask

    task automatic enter_run();
        m_run = 1; m_age = 0; m_strobes = 0; m_under = 0; m_finish = 0;
    endtask

    task automatic reset_checks();
        chk("rst_valid", 32'(bus.sample_valid), 32'd0);
        chk("rst_last", 32'(bus.interval_last), 32'd0);
        chk("rst_sample", 32'(bus.audio_sample), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_under", 32'(underrun_count), 32'd0);
        chk("rst_ready", 32'(bus.wr_ready), 32'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; bus.wr_valid = 1'b0;
        #1;
        m_reset();
        reset_checks();
        @(posedge clk); #1;
        reset_checks();
        rst = 1'b0;
    endtask

    // One clock: drive inputs, advance the model across the edge, compare outputs
    task automatic cycle(input logic wv, input logic signed [15:0] wd, input logic st, input logic sp);
        bit ready_pre;
        bus.wr_valid = wv; bus.wr_data = wd; start = st; stop = sp;
        #1;
        ready_pre = (q.size() < DP);
        chk("wr_ready", 32'(bus.wr_ready), 32'(ready_pre));
        m_valid = 0; m_last = 0;
        if (m_run) begin
            if (sp) begin
                m_run = 0;
            end else if (m_finish) begin
                m_run = 0; m_done = 1; m_armed = 0; m_finish = 0;
            end else begin
                m_age++;
                if (m_age % CD == 0) begin
                    m_valid = 1;
                    m_strobes++;
                    if (q.size() == 0) begin
                        m_sample = 16'sd0;
                        if (m_under < 65535) m_under++;
                    end else begin
                        m_sample = q.pop_front();
                    end
                    m_last = (m_strobes % IL == 0);
                    if (m_strobes == IL * NI) m_finish = 1;
                end
            end
        end else if (m_done) begin
            if (st && m_armed) begin
                m_done = 0;
                enter_run();
            end else begin
                m_armed = m_armed || !st;
            end
        end else if (st && !sp) begin
            enter_run();
        end
        if (wv && ready_pre) q.push_back(wd);
        @(posedge clk); #1;
        chk("sample_valid", 32'(bus.sample_valid), 32'(m_valid));
        chk("interval_last", 32'(bus.interval_last), 32'(m_last));
        chk("audio_sample", 32'(bus.audio_sample), 32'(m_sample));
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("underrun", 32'(underrun_count), 32'(m_under));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int obs_strobes;
        int obs_lasts;
        int bound;
        logic signed [15:0] v5;

        rst = 1'b1; start = 1'b0; stop = 1'b0; sstart = 1'b0; sstop = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_data = 16'sd0;
        sbus.wr_valid = 1'b0; sbus.wr_data = 16'sd0;
        apply_reset();

        // Three queued words paced out on cycles 5, 9, 13, then a zero fill
        cycle(1'b1, 16'sd3, 1'b0, 1'b0);
        cycle(1'b1, -16'sd5, 1'b0, 1'b0);
        cycle(1'b1, 16'sd7, 1'b0, 1'b0);
        cycle(1'b0, 16'sd0, 1'b1, 1'b0);
        repeat (18) cycle(1'b0, 16'sd0, 1'b0, 1'b0);
        chk("first_run_underrun", 32'(underrun_count), 32'd1);
        cycle(1'b0, 16'sd0, 1'b0, 1'b1);

        // Full FIFO rejects a fifth write until the first pop frees a slot
        for (int i = 0; i < DP; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        v5 = 16'($urandom);
        cycle(1'b1, v5, 1'b0, 1'b0);
        chk("full_ready_low", 32'(bus.wr_ready), 32'd0);
        cycle(1'b1, v5, 1'b1, 1'b0);
        repeat (5) cycle(1'b1, v5, 1'b0, 1'b0);
        repeat (16) cycle(1'b0, 16'sd0, 1'b0, 1'b0);
        cycle(1'b0, 16'sd0, 1'b0, 1'b1);

        // Fed full run: 16 strobes, two interval markers, then DONE
        obs_strobes = 0; obs_lasts = 0;
        cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 90; i++) begin
            cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
            if (bus.sample_valid === 1'b1) obs_strobes++;
            if (bus.interval_last === 1'b1) obs_lasts++;
        end
        chk("run_strobe_count", 32'(obs_strobes), 32'd16);
        chk("run_last_count", 32'(obs_lasts), 32'd2);
        chk("run_done", 32'(done), 32'd1);

        // Restart from DONE, drain into underruns, then stop on a tick
        cycle(1'b0, 16'sd0, 1'b1, 1'b0);
        repeat (30) cycle(1'b0, 16'sd0, 1'b0, 1'b0);
        bound = 0;
        while (((m_age + 1) % CD) != 0 && bound < 2 * CD) begin
            cycle(1'b0, 16'sd0, 1'b0, 1'b0);
            bound++;
        end
        cycle(1'b0, 16'sd0, 1'b0, 1'b1);
        chk("stop_no_strobe", 32'(bus.sample_valid), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        repeat (3) cycle(1'b0, 16'sd0, 1'b0, 1'b0);
        cycle(1'b0, 16'sd0, 1'b1, 1'b0);
        chk("restart_clears_under", 32'(underrun_count), 32'd0);

        // Reset right after the third strobe
        obs_strobes = 0; bound = 0;
        while (obs_strobes < 3 && bound < 40) begin
            cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
            if (bus.sample_valid === 1'b1) obs_strobes++;
            bound++;
        end
        chk("third_strobe_seen", 32'(obs_strobes), 32'd3);
        apply_reset();
        cycle(1'b0, 16'sd0, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 16'sd0, 1'b0, 1'b0);
        chk("post_reset_fifo_empty", 32'(underrun_count), 32'd1);
        cycle(1'b0, 16'sd0, 1'b0, 1'b1);

        // Underrun saturation on a divide-by-one instance
        sstart = 1'b1;
        @(posedge clk); #1;
        sstart = 1'b0;
        for (int n = 1; n <= 65600; n++) begin
            @(posedge clk); #1;
            if (n == 10 || n == 65534 || n == 65535 || n == 65536 || n == 65600) begin
                chk("sat_under", 32'(s_under), (n < 65535) ? 32'(n) : 32'd65535);
                chk("sat_valid", 32'(sbus.sample_valid), 32'd1);
                chk("sat_sample", 32'(sbus.audio_sample), 32'd0);
                chk("sat_last", 32'(sbus.interval_last), 32'((n % 8) == 0));
                chk("sat_ready", 32'(sbus.wr_ready), 32'd1);
                chk("sat_busy", 32'(s_busy), 32'd1);
                chk("sat_done", 32'(s_done), 32'd0);
            end
        end
        sstop = 1'b1;
        @(posedge clk); #1;
        sstop = 1'b0;
        @(posedge clk); #1;
        chk("sat_stop_valid", 32'(sbus.sample_valid), 32'd0);
        chk("sat_stop_busy", 32'(s_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
